uart_image_loader: RTL
======================

Name: uart_image_loader

Overview:
- Upstream stage of snn_core. Packs the UART receiver byte stream into one 784-pixel binary image and serves it to the core over a 1-bit read port.
- Issues a single-cycle start pulse once a full image has arrived.
- Blocks new writes until the core reports done, so an image is never modified mid-inference.

Parameters:
- NUM_PIXELS, 784, pixels per image; must be a multiple of 8.
- NUM_BYTES, NUM_PIXELS/8 (98), bytes per image frame.
- ADDR_W, 10, pixel address width.
- TIMEOUT_CYC, 5_000_000, idle cycles (100 ms at 50 MHz) before a partial frame is discarded. Used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- rx_rdy  in  1  single-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- rd_addr  in  ADDR_W  pixel address from core
- rd_q  out  1  pixel value, registered
- core_done  in  1  single-cycle strobe: core finished inference
- start  out  1  single-cycle strobe: image ready
- busy  out  1  high while the image is held for the core
- drop  out  1  single-cycle strobe: a received byte was discarded

Behaviour:
- Reset values:
  - start=0, busy=0, drop=0, rd_q=0.
  - Byte counter = 0, state = FILL.
  - Buffer contents are not reset; they are don't-care until written.
- Pixel mapping: byte k of a frame (k = 0..97) carries pixels 8k..8k+7; bit i of the byte is pixel 8k+i (LSB = lowest address).
- Read port:
  - rd_q is registered: it is the pixel at the rd_addr sampled on the previous clk edge (1-cycle latency).
  - rd_addr >= NUM_PIXELS returns 0.
  - Reads are allowed in every state.
- State FILL:
  - On rx_rdy, write rx_data to byte slot cnt, then cnt <= cnt+1.
  - If cnt == NUM_BYTES-1 on that write: cnt <= 0, go to FIRE.
- State FIRE (one cycle):
  - start=1, busy=1, go to HOLD.
  - start therefore rises the cycle after the rx_rdy of the last byte is sampled.
- State HOLD:
  - busy=1.
  - rx_rdy: byte discarded, drop=1 for that cycle, buffer unchanged, cnt unchanged.
  - core_done: busy <= 0, go to FILL.
  - rx_rdy and core_done in the same cycle: the byte is discarded (drop=1) and the state moves to FILL. The next frame begins with the following byte.
- core_done in FILL or FIRE: ignored.
- rx_rdy on consecutive cycles: every byte is accepted. No back-pressure exists; the receiver cannot stall.
- Reset asserted mid-frame or in HOLD: returns immediately to FILL with cnt=0; the partial frame is abandoned.
- cnt width: ceil(log2(NUM_BYTES)) bits. It never exceeds NUM_BYTES-1.

Optional Feature:
- Macro: UART_IMAGE_LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in FILL while cnt != 0. It clears on every rx_rdy.
  - When it reaches TIMEOUT_CYC-1, cnt <= 0, which resynchronises framing after a lost byte. drop is not pulsed.
  - The counter is held at 0 in FIRE/HOLD and whenever cnt == 0.
- Not defined: no idle counter; a partial frame waits indefinitely.

Decomposition:
- Shared package snn_pkg:
  - NUM_PIXELS, NUM_BYTES, ADDR_W constants.
  - Loader state enum typedef {FILL, FIRE, HOLD}.
- Sub-module img_byte_buf:
  - NUM_BYTES x 8 storage.
  - Write port: byte index, data, we.
  - Read port: pixel address, registered bit-select output (addr[ADDR_W-1:3] selects the byte, addr[2:0] the bit).
- Top FSM, counters and the timeout logic stay in uart_image_loader.

Test Plan:
- 98 bytes of 0x01, rx_rdy every 4 cycles -> start pulses exactly 1 cycle after the 98th rx_rdy, busy=1.
  - rd_addr 0 -> rd_q=1 next cycle; 1 -> 0; 776 -> 1; 783 -> 0.
- Frame of 0x80 then 97 x 0x00, rx_rdy back-to-back every cycle -> all bytes accepted, a single start.
  - Only pixel 7 reads 1; addr 800 reads 0.
- In HOLD, send 3 bytes, then core_done -> drop pulses 3 times, image unchanged, busy falls.
  - A fresh 98-byte frame then produces exactly one start.
- rx_rdy and core_done in the same cycle -> drop=1, FILL entered, cnt=0.
  - 98 further bytes are required before start.
- 50 bytes, then rst_n low for 2 cycles -> no start, busy=0.
  - A subsequent 98 bytes yield start, and the content reflects only the new bytes.
- With UART_IMAGE_LOADER_TIMEOUT_EN, TIMEOUT_CYC=100: 10 bytes, 100 idle cycles, then 98 bytes -> start after byte 98 of the second burst, not byte 88.
  - Without the macro, start follows byte 88.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and loader state type for the SNN image path.
package snn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int NUM_BYTES  = NUM_PIXELS / 8;
    localparam int ADDR_W     = 10;
    localparam int CNT_W      = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } loader_state_e;

    // True when a pixel address falls inside the image.
    function automatic logic pixel_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < ADDR_W'(NUM_PIXELS));
    endfunction

endpackage

// File: rtl/img_byte_buf.sv
// Byte-wide image store with a registered single-pixel read port.
module img_byte_buf
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CNT_W-1:0]  waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rd_q
);

    logic [7:0] mem_r [NUM_BYTES];
    logic       rd_bit_s;

    // Byte write; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Pixel select: upper address bits pick the byte, low three the bit.
    always_comb begin
        rd_bit_s = 1'b0;
        if (pixel_in_range(raddr)) begin
            rd_bit_s = mem_r[raddr[ADDR_W-1:3]][raddr[2:0]];
        end else begin
            rd_bit_s = 1'b0;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_bit_s;
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// Packs UART bytes into a binary image and hands it to the core.
// Optional idle-timeout framing resync: define UART_IMAGE_LOADER_TIMEOUT_EN.
module uart_image_loader
    import snn_pkg::*;
`ifdef UART_IMAGE_LOADER_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 5_000_000
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_q,
    input  logic              core_done,
    output logic              start,
    output logic              busy,
    output logic              drop
);

    loader_state_e    state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             start_r;
    logic             busy_r;
    logic             drop_r;
    logic             we_s;
    logic             timeout_s;

    assign we_s  = (state_r == FILL) && rx_rdy;
    assign start = start_r;
    assign busy  = busy_r;
    assign drop  = drop_r;

`ifdef UART_IMAGE_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    logic [IDLE_W-1:0] idle_r;
    logic              idle_run_s;

    assign idle_run_s = (state_r == FILL) && (cnt_r != '0) && !rx_rdy;
    assign timeout_s  = idle_run_s && (idle_r == IDLE_W'(TIMEOUT_CYC - 1));

    // Idle counter: only runs while a partial frame is waiting for bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r <= '0;
        end else if (!idle_run_s || timeout_s) begin
            idle_r <= '0;
        end else begin
            idle_r <= idle_r + IDLE_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Loader FSM: frame counting, start pulse, hold until core_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
            cnt_r   <= '0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            drop_r  <= 1'b0;
            case (state_r)
                FILL: begin
                    if (rx_rdy) begin
                        if (cnt_r == CNT_W'(NUM_BYTES - 1)) begin
                            cnt_r   <= '0;
                            state_r <= FIRE;
                            start_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else if (timeout_s) begin
                        cnt_r <= '0;
                    end
                end
                FIRE: begin
                    // The image is already frozen here, so a byte is discarded.
                    drop_r  <= rx_rdy;
                    state_r <= HOLD;
                end
                HOLD: begin
                    drop_r <= rx_rdy;
                    if (core_done) begin
                        busy_r  <= 1'b0;
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r <= FILL;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    img_byte_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (cnt_r),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rd_q  (rd_q)
    );

endmodule
